// File: rtl/obuf_pkg.sv
// Shared constants and types for the output-buffer write-side arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package obuf_pkg;

  localparam int DEPTH = 128;  // FIFO depth in entries
  localparam int PTR_W = 8;    // free-slot count width (0..DEPTH)
  localparam int CNT_W = 7;    // packet length / beat counter width

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } wr_arb_state_t;

endpackage

// File: rtl/obuf_wr_arbiter_if.sv
// Requester + FIFO write-port bundle between packet sources and the arbiter.
// Latency: n/a (wires only).
// Backpressure: per-beat via ack (arbiter -> source), FIFO full/free_slots toward the arbiter.
// Signals: req/len/data/last per requester, ack/grant back to requesters,
//          full/free_slots from the FIFO, w_en/w_data into the FIFO.
interface obuf_wr_arbiter_if
  import obuf_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8,
  parameter int LEN_W  = CNT_W,
  parameter int FS_W   = PTR_W
) ();

  logic [NREQ-1:0]        req;
  logic [NREQ*LEN_W-1:0]  len;
  logic [NREQ*DATA_W-1:0] data;
  logic [NREQ-1:0]        last;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        grant;
  logic                   full;
  logic [FS_W-1:0]        free_slots;
  logic                   w_en;
  logic [DATA_W-1:0]      w_data;

  // arbiter side
  modport slave (
    input  req, len, data, last, full, free_slots,
    output ack, grant, w_en, w_data
  );

  // sources + FIFO side
  modport master (
    output req, len, data, last, full, free_slots,
    input  ack, grant, w_en, w_data
  );

endinterface

// File: rtl/obuf_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible after rr_ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; found=0 when nothing is eligible.
// Ports: eligible (NREQ), rr_ptr (last winner) in; found, onehot, index out.
module obuf_rr_pick
  import obuf_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    int c;
    found  = 1'b0;
    onehot = '0;
    index  = '0;
    c      = 0;
    // Scan rr_ptr+1 .. rr_ptr+NREQ so the previous winner is checked last.
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(rr_ptr) + k) % NREQ;
      if (!found && eligible[c]) begin
        found     = 1'b1;
        onehot[c] = 1'b1;
        index     = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/obuf_wr_arbiter.sv
// Round-robin packet scheduler sharing one FIFO write port among NREQ sources.
// Latency: 1 cycle req->grant; beats written same cycle as req&~full while granted.
// Backpressure: grant only when free_slots covers the whole packet; full or owner req low stalls.
// Ports: w_clk, n_rst (async, active-low); bus (slave modport: req/len/data/last/ack/grant,
//        full/free_slots/w_en/w_data); busy (in BURST), err (sticky length violation), err_clr.
module obuf_wr_arbiter
  import obuf_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8,
  parameter int DEPTH  = obuf_pkg::DEPTH
) (
  input  logic                w_clk,
  input  logic                n_rst,
  obuf_wr_arbiter_if.slave    bus,
  output logic                busy,
  output logic                err,
  input  logic                err_clr
);

  localparam int LEN_W = $clog2(DEPTH);
  localparam int FS_W  = LEN_W + 1;
  localparam int IDX_W = $clog2(NREQ);

  wr_arb_state_t     state;
  logic [NREQ-1:0]   grant_q;
  logic [IDX_W-1:0]  owner_q;
  logic [IDX_W-1:0]  rr_ptr;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;

  logic [NREQ-1:0]   eligible;
  logic              pick_found;
  logic [NREQ-1:0]   pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic [LEN_W-1:0]  pick_len;

  logic              own_req;
  logic              own_last;
  logic [DATA_W-1:0] own_data;
  logic              wr_fire;
  logic              at_len;
  logic              pkt_end;
  logic              viol;

  // A source is eligible only if the FIFO can absorb its whole packet.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = bus.req[i] &&
                    (({1'b0, bus.len[i*LEN_W +: LEN_W]} + FS_W'(1)) <= bus.free_slots);
    end
  end

  obuf_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .found    (pick_found),
    .onehot   (pick_oh),
    .index    (pick_idx)
  );

  // Length of the winner, captured at grant.
  always_comb begin
    pick_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_len = bus.len[i*LEN_W +: LEN_W];
    end
  end

  // Owner's live inputs; everyone else is ignored during a burst.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_req  = bus.req[i];
        own_last = bus.last[i];
        own_data = bus.data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wr_fire = (state == BURST) && own_req && !bus.full;
  assign at_len  = (beat_cnt == len_q);
  assign pkt_end = wr_fire && (own_last || at_len);
  // Early last (last before len reached) or overrun (len reached without last).
  assign viol    = wr_fire && (own_last ^ at_len);

  assign bus.w_en   = wr_fire;
  assign bus.w_data = own_data;
  assign bus.ack    = grant_q & {NREQ{wr_fire}};
  assign bus.grant  = grant_q;

  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr   <= IDX_W'(NREQ - 1);
      len_q    <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Set has priority over clear.
      if (viol)         err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= BURST;
            busy     <= 1'b1;
            grant_q  <= pick_oh;
            owner_q  <= pick_idx;
            len_q    <= pick_len;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (wr_fire) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (pkt_end) begin
              state   <= IDLE;
              busy    <= 1'b0;
              grant_q <= '0;
              rr_ptr  <= owner_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obuf_wr_arbiter.sv
// Directed bench for obuf_wr_arbiter with two requesters.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_obuf_wr_arbiter;
  import obuf_pkg::*;

  logic        w_clk = 1'b0;
  logic        n_rst;
  logic        busy;
  logic        err;
  logic        err_clr;
  logic [1:0]  req;
  logic [13:0] len;
  logic [15:0] data;
  logic [1:0]  last;
  logic        full;
  logic [7:0]  free_slots;

  int total = 0;
  int bad   = 0;

  always #5 w_clk = ~w_clk;

  obuf_wr_arbiter_if #(.NREQ(2), .DATA_W(8)) bus ();

  assign bus.req        = req;
  assign bus.len        = len;
  assign bus.data       = data;
  assign bus.last       = last;
  assign bus.full       = full;
  assign bus.free_slots = free_slots;

  obuf_wr_arbiter #(.NREQ(2), .DATA_W(8), .DEPTH(128)) dut (
    .w_clk   (w_clk),
    .n_rst   (n_rst),
    .bus     (bus.slave),
    .busy    (busy),
    .err     (err),
    .err_clr (err_clr)
  );

  task automatic cyc();
    @(posedge w_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge w_clk);
  endtask

  task automatic do_reset();
    n_rst = 1'b0; req = '0; last = '0; len = '0; data = '0;
    full = 1'b0; err_clr = 1'b0; free_slots = 8'd128;
    cyc(); cyc();
    n_rst = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    n_rst = 1'b0; req = 2'b01; last = '0; len = '0; data = 16'h5555;
    full = 1'b0; err_clr = 1'b0; free_slots = 8'd128;
    #2;
    total++;
    if ({grant_v(), busy, err, bus.w_en, bus.ack} !== 7'b0) begin
      bad++;
      $display("FAIL reset_async: grant=%b busy=%b err=%b w_en=%b ack=%b, want all 0",
               bus.grant, busy, err, bus.w_en, bus.ack);
    end
    mid();
    total++;
    if (bus.grant !== 2'b00 || bus.w_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: grant=%b w_en=%b, want 00/0", bus.grant, bus.w_en);
    end
    cyc();
    req = '0;
    n_rst = 1'b1;
    cyc();
  endtask

  function automatic logic [1:0] grant_v();
    return bus.grant;
  endfunction

  task automatic test_single();
    len[6:0] = 7'd3; data[7:0] = 8'hA0; last = '0; req = 2'b01;
    mid();
    total++;
    if (bus.grant !== 2'b00 || bus.w_en !== 1'b0) begin
      bad++;
      $display("FAIL single_latency: grant=%b w_en=%b, want 00/0", bus.grant, bus.w_en);
    end
    cyc();
    for (int b = 0; b < 4; b++) begin
      data[7:0] = 8'hA0 + 8'(b);
      last[0]  = (b == 3);
      mid();
      total++;
      if (bus.w_en !== 1'b1 || bus.w_data !== 8'hA0 + 8'(b) || bus.ack !== 2'b01 ||
          bus.grant !== 2'b01 || busy !== 1'b1) begin
        bad++;
        $display("FAIL single_beat%0d: w_en=%b w_data=%h ack=%b grant=%b busy=%b, want 1/%h/01/01/1",
                 b, bus.w_en, bus.w_data, bus.ack, bus.grant, busy, 8'hA0 + 8'(b));
      end
      cyc();
    end
    req = '0; last = '0;
    mid();
    total++;
    if (bus.grant !== 2'b00 || busy !== 1'b0 || err !== 1'b0 || bus.w_en !== 1'b0) begin
      bad++;
      $display("FAIL single_end: grant=%b busy=%b err=%b w_en=%b, want 00/0/0/0",
               bus.grant, busy, err, bus.w_en);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    len = {7'd1, 7'd1};
    req = 2'b11;
    for (int p = 0; p < 4; p++) begin
      exp = (p % 2 == 0) ? 2'b01 : 2'b10;
      mid();
      total++;
      if (bus.grant !== 2'b00 || bus.w_en !== 1'b0) begin
        bad++;
        $display("FAIL rr_gap%0d: grant=%b w_en=%b, want 00/0", p, bus.grant, bus.w_en);
      end
      cyc();
      for (int b = 0; b < 2; b++) begin
        last = (b == 1) ? 2'b11 : 2'b00;
        data = {8'h40 + 8'(2*p + b), 8'h20 + 8'(2*p + b)};
        mid();
        total++;
        if (bus.grant !== exp || bus.ack !== exp || bus.w_en !== 1'b1 ||
            bus.w_data !== ((p % 2 == 0) ? 8'h20 + 8'(2*p + b) : 8'h40 + 8'(2*p + b))) begin
          bad++;
          $display("FAIL rr_pkt%0d_beat%0d: grant=%b ack=%b w_en=%b w_data=%h, want grant=%b",
                   p, b, bus.grant, bus.ack, bus.w_en, bus.w_data, exp);
        end
        cyc();
      end
      last = '0;
    end
    req = '0;
    cyc();
  endtask

  task automatic test_space_gating();
    int wr;
    len[6:0] = 7'd9; free_slots = 8'd9; req = 2'b01; last = '0;
    for (int k = 0; k < 2; k++) begin
      mid();
      total++;
      if (bus.grant !== 2'b00) begin
        bad++;
        $display("FAIL space_block%0d: grant=%b, want 00 (10 beats, 9 free)", k, bus.grant);
      end
      cyc();
    end
    free_slots = 8'd10;
    mid();
    cyc();
    wr = 0;
    for (int b = 0; b < 10; b++) begin
      last[0] = (b == 9);
      mid();
      if (b == 0) begin
        total++;
        if (bus.grant !== 2'b01) begin
          bad++;
          $display("FAIL space_grant: grant=%b, want 01", bus.grant);
        end
      end
      if (bus.w_en === 1'b1) wr++;
      cyc();
    end
    req = '0; last = '0; free_slots = 8'd128;
    mid();
    total++;
    if (wr !== 10 || bus.grant !== 2'b00 || err !== 1'b0) begin
      bad++;
      $display("FAIL space_pkt: writes=%0d grant=%b err=%b, want 10/00/0", wr, bus.grant, err);
    end
    cyc();
  endtask

  task automatic test_stall();
    int wr;
    len[6:0] = 7'd3; req = 2'b01; last = '0; full = 1'b0;
    mid();
    cyc();
    wr = 0;
    mid();
    if (bus.w_en === 1'b1) wr++;
    cyc();
    req = 2'b00;
    for (int k = 0; k < 2; k++) begin
      mid();
      total++;
      if (bus.w_en !== 1'b0 || bus.grant !== 2'b01 || bus.ack !== 2'b00) begin
        bad++;
        $display("FAIL stall_req%0d: w_en=%b grant=%b ack=%b, want 0/01/00",
                 k, bus.w_en, bus.grant, bus.ack);
      end
      cyc();
    end
    req = 2'b01; full = 1'b1;
    mid();
    total++;
    if (bus.w_en !== 1'b0 || bus.grant !== 2'b01) begin
      bad++;
      $display("FAIL stall_full: w_en=%b grant=%b, want 0/01", bus.w_en, bus.grant);
    end
    cyc();
    full = 1'b0;
    for (int b = 1; b < 4; b++) begin
      last[0] = (b == 3);
      mid();
      if (bus.w_en === 1'b1) wr++;
      cyc();
    end
    req = '0; last = '0;
    mid();
    total++;
    if (wr !== 4 || bus.grant !== 2'b00 || err !== 1'b0) begin
      bad++;
      $display("FAIL stall_total: writes=%0d grant=%b err=%b, want 4/00/0", wr, bus.grant, err);
    end
    cyc();
  endtask

  task automatic test_len_err();
    // early last: len=4, last on second beat
    len[6:0] = 7'd4; req = 2'b01; last = '0;
    mid(); cyc();
    mid(); cyc();
    last[0] = 1'b1;
    mid();
    total++;
    if (err !== 1'b0 || bus.w_en !== 1'b1) begin
      bad++;
      $display("FAIL early_pre: err=%b w_en=%b, want 0/1", err, bus.w_en);
    end
    cyc();
    req = '0; last = '0;
    mid();
    total++;
    if (err !== 1'b1 || bus.grant !== 2'b00) begin
      bad++;
      $display("FAIL early_last: err=%b grant=%b, want 1/00", err, bus.grant);
    end
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    mid();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: err=%b, want 0", err);
    end
    cyc();
    // overrun: len=2, last never asserted
    len[6:0] = 7'd2; req = 2'b01;
    mid(); cyc();
    for (int b = 0; b < 3; b++) begin
      mid();
      total++;
      if (bus.w_en !== 1'b1) begin
        bad++;
        $display("FAIL overrun_beat%0d: w_en=%b, want 1", b, bus.w_en);
      end
      cyc();
    end
    req = '0;
    mid();
    total++;
    if (err !== 1'b1 || bus.grant !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL overrun_end: err=%b grant=%b busy=%b, want 1/00/0", err, bus.grant, busy);
    end
    cyc();
    // clear during first beat, then clear coinciding with an early last
    len[6:0] = 7'd4; req = 2'b01;
    mid(); cyc();
    err_clr = 1'b1;
    mid(); cyc();
    last[0] = 1'b1;
    mid();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL clr_mid: err=%b, want 0", err);
    end
    cyc();
    err_clr = 1'b0; last = '0; req = '0;
    mid();
    total++;
    if (err !== 1'b1 || bus.grant !== 2'b00) begin
      bad++;
      $display("FAIL set_beats_clr: err=%b grant=%b, want 1/00", err, bus.grant);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    len[6:0] = 7'd5; req = 2'b01; last = '0;
    mid(); cyc();
    for (int b = 0; b < 2; b++) begin
      mid();
      total++;
      if (bus.w_en !== 1'b1 || err !== 1'b1) begin
        bad++;
        $display("FAIL rstmid_beat%0d: w_en=%b err=%b, want 1/1", b, bus.w_en, err);
      end
      cyc();
    end
    n_rst = 1'b0;
    #1;
    total++;
    if (bus.grant !== 2'b00 || bus.w_en !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async: grant=%b w_en=%b err=%b busy=%b, want 00/0/0/0",
               bus.grant, bus.w_en, err, busy);
    end
    req = 2'b11; len = '0; last = 2'b11;
    cyc();
    mid();
    n_rst = 1'b1;
    cyc();
    mid();
    total++;
    if (bus.grant !== 2'b01 || bus.w_en !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_prio: grant=%b w_en=%b, want 01/1", bus.grant, bus.w_en);
    end
    cyc();
    mid();
    total++;
    if (bus.grant !== 2'b00) begin
      bad++;
      $display("FAIL len0_end: grant=%b, want 00", bus.grant);
    end
    cyc();
    mid();
    total++;
    if (bus.grant !== 2'b10 || bus.ack !== 2'b10) begin
      bad++;
      $display("FAIL rstmid_next: grant=%b ack=%b, want 10/10", bus.grant, bus.ack);
    end
    cyc();
    req = '0; last = '0;
    mid();
    total++;
    if (bus.grant !== 2'b00 || err !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_final: grant=%b err=%b, want 00/0", bus.grant, err);
    end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_space_gating();
    test_stall();
    test_len_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
